// File: rtl/matrix_multiplier_seq.sv
// ---------------------------------------------------------------------------
// matrix_multiplier_seq : sequential DIM x DIM signed fixed-point C = A*B / A*B^T
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module matrix_multiplier_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int DIM   = 4
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            start,
  input  logic                            transB,
  input  logic [DIM*DIM-1:0][WIDTH-1:0]   matA,
  input  logic [DIM*DIM-1:0][WIDTH-1:0]   matB,
  output logic                            busy,
  output logic                            done,
  output logic [DIM*DIM-1:0][WIDTH-1:0]   res_mat,
  output logic                            overflow
);

  localparam int N     = DIM * DIM;
  localparam int IDX_W = $clog2(N);
  localparam int RC_W  = $clog2(DIM);
  localparam int SUM_W = 2 * WIDTH + $clog2(DIM);

  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(1) << (FRAC - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [RC_W-1:0]               row_q, row_d;
  logic [RC_W-1:0]               col_q, col_d;
  logic [N-1:0][WIDTH-1:0]       a_q, a_d;
  logic [N-1:0][WIDTH-1:0]       b_q, b_d;
  logic                          trans_q, trans_d;
  logic [N-1:0][WIDTH-1:0]       work_q, work_d;
  logic                          ovf_work_q, ovf_work_d;
  logic [N-1:0][WIDTH-1:0]       res_q, res_d;
  logic                          ovf_q, ovf_d;
  logic                          done_q, done_d;

  logic [WIDTH-1:0]              a_el;
  logic [WIDTH-1:0]              b_el;
  logic signed [2*WIDTH-1:0]     prod;
  logic signed [SUM_W-1:0]       sum;
  logic signed [SUM_W-1:0]       rounded;
  logic [WIDTH-1:0]              sat_val;
  logic                          clamp;

  // Dot product of row row_q of A with column col_q of B (or row col_q when transposed)
  always_comb begin
    sum  = '0;
    a_el = '0;
    b_el = '0;
    prod = '0;
    for (int k = 0; k < DIM; k++) begin
      a_el = a_q[IDX_W'(int'(row_q) * DIM + k)];
      b_el = trans_q ? b_q[IDX_W'(int'(col_q) * DIM + k)]
                     : b_q[IDX_W'(k * DIM + int'(col_q))];
      prod = $signed({{WIDTH{a_el[WIDTH-1]}}, a_el}) *
             $signed({{WIDTH{b_el[WIDTH-1]}}, b_el});
      sum  = sum + {{(SUM_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    end
    rounded = (sum + RND) >>> FRAC;
    clamp   = 1'b0;
    sat_val = rounded[WIDTH-1:0];
    if (rounded > SAT_MAX) begin
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
      clamp   = 1'b1;
    end else if (rounded < SAT_MIN) begin
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
      clamp   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    a_d        = a_q;
    b_d        = b_q;
    trans_d    = trans_q;
    work_d     = work_q;
    ovf_work_d = ovf_work_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = matA;
          b_d        = matB;
          trans_d    = transB;
          ovf_work_d = 1'b0;
          idx_d      = '0;
          row_d      = '0;
          col_d      = '0;
          state_d    = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        work_d[idx_q] = sat_val;
        ovf_work_d    = ovf_work_q | clamp;
        if (idx_q == IDX_W'(N - 1)) begin
          // Publish on the edge into DONE so the outputs are valid while done is high
          state_d = S_DONE;
          res_d   = work_d;
          ovf_d   = ovf_work_d;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == RC_W'(DIM - 1)) begin
            col_d = '0;
            row_d = row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      trans_q    <= 1'b0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      a_q        <= a_d;
      b_q        <= b_d;
      trans_q    <= trans_d;
      work_q     <= work_d;
      ovf_work_q <= ovf_work_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign res_mat  = res_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_multiplier_seq.sv
// ---------------------------------------------------------------------------
// tb_matrix_multiplier_seq : directed scoreboard bench for matrix_multiplier_seq
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_matrix_multiplier_seq;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int DIM   = 4;
  localparam int N     = DIM * DIM;

  typedef logic [N-1:0][WIDTH-1:0] mat_t;
  typedef struct {
    mat_t res;
    logic ovf;
    int   done_edge;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset, start, transB;
  mat_t matA, matB, res_mat;
  logic busy, done, overflow;

  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  exp_t sb_q[$];

  matrix_multiplier_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .DIM(DIM)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .transB   (transB),
    .matA     (matA),
    .matB     (matB),
    .busy     (busy),
    .done     (done),
    .res_mat  (res_mat),
    .overflow (overflow)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) edges = edges + 1;

  task automatic check(input string name, input logic [N*WIDTH-1:0] act, input logic [N*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mat_t pack(input int v[16]);
    mat_t m;
    for (int i = 0; i < N; i++) m[i] = WIDTH'(v[i]);
    return m;
  endfunction

  function automatic mat_t diag(input logic [WIDTH-1:0] d);
    mat_t m = '0;
    for (int i = 0; i < DIM; i++) m[i*DIM+i] = d;
    return m;
  endfunction

  function automatic mat_t fill(input logic [WIDTH-1:0] d);
    mat_t m;
    for (int i = 0; i < N; i++) m[i] = d;
    return m;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (!Reset && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", edges);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res_mat",    res_mat,  e.res);
        check("overflow",   overflow, e.ovf);
        check("done_cycle", edges,    e.done_edge);
      end
    end
  end

  task automatic run_op(input mat_t a, input mat_t b, input logic t,
                        input mat_t er, input logic eo, input int pulse);
    exp_t e;
    int   cnt;
    @(negedge Clk);
    matA   = a;
    matB   = b;
    transB = t;
    start  = 1'b1;
    e.res       = er;
    e.ovf       = eo;
    e.done_edge = edges + 17;
    sb_q.push_back(e);
    @(negedge Clk);
    start  = 1'b0;
    matA   = ~a;
    transB = ~t;
    cnt    = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == pulse) begin
        start = 1'b1;
        matB  = '0;
      end else begin
        start = 1'b0;
      end
      if (!busy) break;
      cnt++;
      @(negedge Clk);
    end
    start = 1'b0;
    check("busy_cycles", cnt, 17);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   v_seq[16], v_b2[16], v_e2[16], v_ones_n[16], v_ones_t[16], v_seq_t[16];
    mat_t m;
    mat_t m_r;

    v_seq    = '{0,1,2,3, 4,5,6,7, 8,9,10,11, 12,13,14,15};
    v_b2     = '{0,'h234,0,0, 'h567,0,'hAB,0, 0,0,0,0, 0,0,0,'h100};
    v_e2     = '{0,'h567,0,0, 'h234,0,0,0, 0,'hAB,0,0, 0,0,0,'h100};
    v_ones_n = '{24,28,32,36, 24,28,32,36, 24,28,32,36, 24,28,32,36};
    v_ones_t = '{6,22,38,54, 6,22,38,54, 6,22,38,54, 6,22,38,54};
    v_seq_t  = '{0,4,8,12, 1,5,9,13, 2,6,10,14, 3,7,11,15};

    Reset = 1'b1; start = 1'b0; transB = 1'b0; matA = '0; matB = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_res_mat",  res_mat,  0);
    check("rst_overflow", overflow, 0);
    Reset = 1'b0;

    run_op(diag(16'h0100), pack(v_seq), 1'b0, pack(v_seq), 1'b0, 0);
    run_op(diag(16'h0100), pack(v_b2),  1'b1, pack(v_e2),  1'b0, 0);
    run_op(fill(16'h0100), pack(v_seq), 1'b0, pack(v_ones_n), 1'b0, 0);
    run_op(fill(16'h0100), pack(v_seq), 1'b1, pack(v_ones_t), 1'b0, 0);
    run_op(fill(16'h7F00), fill(16'h7F00), 1'b0, fill(16'h7FFF), 1'b1, 0);
    run_op(diag(16'h0100), diag(16'h0100), 1'b0, diag(16'h0100), 1'b0, 0);
    run_op(diag(16'hFF00), fill(16'h0180), 1'b0, fill(16'hFE80), 1'b0, 0);

    m = '0; m[0] = 16'h0001;
    m_r = '0; m_r[0] = 16'h0080;
    run_op(m, m_r, 1'b0, mat_t'(1), 1'b0, 0);
    m_r[0] = 16'h007F;
    run_op(m, m_r, 1'b0, mat_t'(0), 1'b0, 0);

    // Extra start pulse in cycle 5 must be ignored
    run_op(diag(16'h8000), fill(16'h7F00), 1'b0, fill(16'h8000), 1'b1, 5);

    // Abort: start at edge 0, Reset sampled at edge 8
    @(negedge Clk);
    matA = fill(16'h7F00); matB = fill(16'h7F00); transB = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_busy",     busy,     0);
    check("abort_done",     done,     0);
    check("abort_res_mat",  res_mat,  0);
    check("abort_overflow", overflow, 0);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);

    run_op(diag(16'h0100), pack(v_seq), 1'b1, pack(v_seq_t), 1'b0, 0);

    repeat (3) @(negedge Clk);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
